// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel magnitude stage for a raster-order 8-bit gray stream.
// Two line buffers feed a shifting window. Each interior pixel yields one saturated |Gx|+|Gy| result.
module sobel_edge #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       valid_i,
   input  logic [7:0] GrayColor_i,
   output logic       valid_o,
   output logic [7:0] EdgeColor_o,
   output logic       done_o
);

   localparam int DATA_W = 8;
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   function automatic logic signed [10:0] ext(input logic [DATA_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   function automatic logic [11:0] abs11(input logic signed [10:0] v);
      return v[10] ? 12'(-v) : 12'(v);
   endfunction

   function automatic logic [DATA_W-1:0] sat8(input logic [11:0] m);
      return (m > 12'd255) ? 8'hFF : m[DATA_W-1:0];
   endfunction

   logic [0:0]        state;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] lb0_rd;
   logic [DATA_W-1:0] lb1_rd;
   logic [DATA_W-1:0] win_p0 [3][3];
   logic              vld_p0;
   logic              last_p0;
   logic              accept;

   logic signed [10:0] gx_p0;
   logic signed [10:0] gy_p0;
   logic        [11:0] mag_p0;

   // start_i takes precedence, so a pixel arriving with it is dropped
   assign accept = (state == S_RUN) && valid_i && !start_i;
   assign lb0_rd = lb0[col];
   assign lb1_rd = lb1[col];

   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb1[col] <= lb0_rd;
         lb0[col] <= GrayColor_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         col     <= '0;
         row     <= '0;
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end else begin
         vld_p0  <= accept && (row >= ROW_TWO) && (col >= COL_TWO);
         last_p0 <= accept && (row == ROW_LAST) && (col == COL_LAST);
         if (start_i) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
         end else if (accept) begin
            if (col == COL_LAST) begin
               col <= '0;
               if (row == ROW_LAST) begin
                  row   <= '0;
                  state <= S_IDLE;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Stage p0: window shifts left, new right column is {row-2, row-1, current}
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_p0[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_p0[r][0] <= win_p0[r][1];
            win_p0[r][1] <= win_p0[r][2];
         end
         win_p0[0][2] <= lb1_rd;
         win_p0[1][2] <= lb0_rd;
         win_p0[2][2] <= GrayColor_i;
      end
   end

   always_comb begin
      gx_p0  = (ext(win_p0[0][2]) + (ext(win_p0[1][2]) <<< 1) + ext(win_p0[2][2]))
             - (ext(win_p0[0][0]) + (ext(win_p0[1][0]) <<< 1) + ext(win_p0[2][0]));
      gy_p0  = (ext(win_p0[2][0]) + (ext(win_p0[2][1]) <<< 1) + ext(win_p0[2][2]))
             - (ext(win_p0[0][0]) + (ext(win_p0[0][1]) <<< 1) + ext(win_p0[0][2]));
      mag_p0 = abs11(gx_p0) + abs11(gy_p0);
   end

   // Stage p1: registered result, value holds between pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o     <= 1'b0;
         EdgeColor_o <= '0;
         done_o      <= 1'b0;
      end else begin
         valid_o <= vld_p0;
         done_o  <= vld_p0 && last_p0;
         if (vld_p0) begin
            EdgeColor_o <= sat8(mag_p0);
         end
      end
   end

endmodule

// File: tb/tb_sobel_edge.sv
// Directed scoreboard bench for sobel_edge on a 4x4 image.
module tb_sobel_edge;
   localparam int W = 4;
   localparam int H = 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       valid_i = 1'b0;
   logic [7:0] GrayColor_i = 8'h00;
   logic       valid_o;
   logic [7:0] EdgeColor_o;
   logic       done_o;

   typedef struct {
      int exp_edge;
      bit exp_done;
      int exp_cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_valid = 0;
   int   fr[H][W];

   sobel_edge #(.IMG_W(W), .IMG_H(H)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .valid_i    (valid_i),
      .GrayColor_i(GrayColor_i),
      .valid_o    (valid_o),
      .EdgeColor_o(EdgeColor_o),
      .done_o     (done_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic int sob(input int r, input int c);
      int p[3][3];
      int gx, gy, m;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = fr[r-2+i][c-2+j];
      gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 255) ? 255 : m;
   endfunction

   always @(negedge clk_i) begin
      if (valid_o) begin
         n_valid++;
         checks++;
         assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_valid: got EdgeColor_o=%0d with no result due", EdgeColor_o);
         end
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks += 3;
            assert (EdgeColor_o === 8'(e.exp_edge)) else begin
               errors++;
               $error("FAIL edge_value: got %0d expected %0d", EdgeColor_o, e.exp_edge);
            end
            assert (done_o === e.exp_done) else begin
               errors++;
               $error("FAIL done_flag: got %0b expected %0b", done_o, e.exp_done);
            end
            assert (cyc === e.exp_cyc) else begin
               errors++;
               $error("FAIL latency: result at cycle %0d expected cycle %0d", cyc, e.exp_cyc);
            end
         end
      end else begin
         checks++;
         assert (done_o === 1'b0) else begin
            errors++;
            $error("FAIL done_without_valid: got done_o=%b expected 0", done_o);
         end
      end
   end

   task automatic drv(input bit s, input bit v, input logic [7:0] d);
      @(negedge clk_i);
      start_i     = s;
      valid_i     = v;
      GrayColor_i = d;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i   = 1'b1;
      start_i = 1'b0;
      valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      sbq.delete();
   endtask

   task automatic fill(input int kind, input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (kind)
               0:       fr[r][c] = v;
               1:       fr[r][c] = (c >= 2) ? 255 : 0;
               2:       fr[r][c] = 10*c + 5*r;
               default: fr[r][c] = int'($urandom_range(0, 255));
            endcase
   endtask

   task automatic send(input int n, input int gap, input bit expect_out);
      for (int i = 0; i < n; i++) begin
         int r, c;
         r = i / W;
         c = i % W;
         drv(1'b0, 1'b1, 8'(fr[r][c]));
         if (expect_out && r >= 2 && c >= 2)
            sbq.push_back('{sob(r, c), (i == W*H-1), cyc + 2});
         repeat (gap) drv(1'b0, 1'b0, 8'h00);
      end
      drv(1'b0, 1'b0, 8'h00);
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 20) begin
         drv(1'b0, 1'b0, 8'h00);
         t++;
      end
      drv(1'b0, 1'b0, 8'h00);
      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain: %0d results missing, expected 0", tag, sbq.size());
      end
   endtask

   task automatic check_quiet(input string tag);
      checks += 3;
      assert (valid_o === 1'b0) else begin
         errors++;
         $error("FAIL %s_valid: got %b expected 0", tag, valid_o);
      end
      assert (EdgeColor_o === 8'h00) else begin
         errors++;
         $error("FAIL %s_edge: got %0d expected 0", tag, EdgeColor_o);
      end
      assert (done_o === 1'b0) else begin
         errors++;
         $error("FAIL %s_done: got %b expected 0", tag, done_o);
      end
   endtask

   initial begin
      int nv;

      do_reset();
      check_quiet("reset");

      fill(0, 8'hEE);
      drv(1'b1, 1'b0, 8'h00);
      send(W*H, 0, 1'b1);
      drain("uniform");

      fill(1, 0);
      drv(1'b1, 1'b0, 8'h00);
      send(W*H, 0, 1'b1);
      drain("step");

      fill(2, 0);
      drv(1'b1, 1'b0, 8'h00);
      send(W*H, 0, 1'b1);
      drain("ramp");

      nv = n_valid;
      send(W*H, 0, 1'b0);
      repeat (3) drv(1'b0, 1'b0, 8'h00);
      checks++;
      assert (n_valid == nv) else begin
         errors++;
         $error("FAIL idle_ignore: got %0d pulses expected 0", n_valid - nv);
      end

      drv(1'b1, 1'b0, 8'h00);
      send(11, 0, 1'b1);
      do_reset();
      check_quiet("midreset");
      nv = n_valid;
      send(W*H, 0, 1'b0);
      repeat (3) drv(1'b0, 1'b0, 8'h00);
      checks++;
      assert (n_valid == nv) else begin
         errors++;
         $error("FAIL post_reset_ignore: got %0d pulses expected 0", n_valid - nv);
      end
      drv(1'b1, 1'b0, 8'h00);
      send(W*H, 0, 1'b1);
      drain("ramp_after_reset");

      drv(1'b1, 1'b1, 8'hFF);
      send(W*H, 2, 1'b1);
      drain("ramp_gapped");

      fill(3, 0);
      drv(1'b1, 1'b0, 8'h00);
      send(9, 0, 1'b1);
      fill(0, 8'h10);
      nv = n_valid;
      drv(1'b1, 1'b0, 8'h00);
      send(W*H, 0, 1'b1);
      drain("restart");
      checks++;
      assert (n_valid - nv == 4) else begin
         errors++;
         $error("FAIL restart_count: got %0d pulses expected 4", n_valid - nv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge stage directly downstream of the sequential RGB-to-gray converter. Consumes the converter's gray-pixel stream (one byte per `valid` pulse, raster order), keeps two line buffers plus a 3x3 window, and emits one saturated gradient magnitude per interior pixel. Output feeds the Avalon write-back side of the edge-detection filter.

## Interface
- `IMG_W`, default 256: image width in pixels, ≥ 3.
- `IMG_H`, default 256: image height in pixels, ≥ 3.
- `clk_i` input, 1 bit: single clock, rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `start_i` input, 1 bit: one-cycle pulse that begins a frame and clears the row/column counters.
- `valid_i` input, 1 bit: `GrayColor_i` holds a pixel this cycle. Connects to the converter's `valid_o`.
- `GrayColor_i` input, 8 bits: gray pixel, unsigned.
- `valid_o` output, 1 bit: `EdgeColor_o` holds a result this cycle (single-cycle pulse per result).
- `EdgeColor_o` output, 8 bits: saturated Sobel magnitude.
- `done_o` output, 1 bit: asserted in the same cycle as the last result of the frame.

## Operation
- **States**
  - IDLE (after reset): `valid_i` is ignored. `start_i` sets row = 0, col = 0 and moves to RUN.
  - RUN: each cycle with `valid_i` = 1 accepts one pixel at (row, col).
    - col increments and wraps at `IMG_W`-1 to 0, and row then increments.
    - Accepting pixel (`IMG_H`-1, `IMG_W`-1) returns the block to IDLE.
- **Line buffers:** two `IMG_W` x 8 memories, indexed by col.
  - On accept, read lb1[col] and lb0[col], then write lb1[col] ← lb0[col] and lb0[col] ← `GrayColor_i`.
  - lb1 therefore holds row-2 and lb0 holds row-1.
- **Window:** 3x3 registers p[r][c] shift left on accept. The new right column is {lb1[col], lb0[col], `GrayColor_i`} (top to bottom).
- **Window valid:** a window is valid when the accepted pixel has row ≥ 2 and col ≥ 2. Its center is pixel (row-1, col-1).
  - Columns that wrap across a row boundary are never flagged valid.
  - Each frame yields (`IMG_W`-2)·(`IMG_H`-2) results. No border outputs and no padding.
- **Arithmetic:** signed, 11 bits.
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Each of Gx and Gy lies in ±1020.
  - mag = |Gx| + |Gy| in 12 bits unsigned, maximum 2040.
  - `EdgeColor_o` = mag if mag ≤ 255, otherwise 255.
- **Simultaneous events**
  - `start_i` in RUN restarts the frame: counters clear and no output is produced until the new row-2/col-2 point. Line-buffer contents are don't-care because they are masked by the counters.
  - `start_i` and `valid_i` in the same cycle: `start_i` wins and the pixel is dropped.
- **Reset:** `rst_i` has priority over everything.
  - State returns to IDLE. Counters, window and all outputs clear.
  - Line-buffer memories are not cleared.

## Timing
- **Reset values:** `valid_o` = 0, `EdgeColor_o` = 0, `done_o` = 0.
- **Latency:** a pixel accepted at edge k (window updated at k) produces `valid_o` / `EdgeColor_o` registered at edge k+1. This is one cycle of output latency after the window load.
- **Output hold:** `EdgeColor_o` holds its last value when `valid_o` = 0.
- **Throughput:** one pixel per cycle. `valid_i` may have arbitrary gaps, and gaps do not change results. There is no backpressure: the consumer must accept every `valid_o` pulse.
- **Frame end:** `done_o` pulses with the result produced by the final accepted pixel. The block is in IDLE on the cycle `done_o` is high.
- **Counter widths:** col uses $clog2(`IMG_W`) bits and row uses $clog2(`IMG_H`) bits.

## Test plan
All scenarios use `IMG_W` = `IMG_H` = 4, so each frame gives 4 results.
- **Uniform frame:** reset, `start_i`, then 16 pixels of 0xEE back-to-back → four `valid_o` pulses, all `EdgeColor_o` = 0. `done_o` is high on the 4th pulse. The first pulse comes one cycle after the pixel at (2,2) is accepted.
- **Vertical step:** columns 0–1 = 0, columns 2–3 = 255 → |Gx| = 1020, so all four results saturate to 255.
- **Ramp:** pixel = 10·col + 5·row → Gx = 80, Gy = 40, so all four results are 120.
  - Repeat with `valid_i` high only every third cycle → identical values and count.
- **Restart and ignore:** `start_i` mid-frame after 9 pixels, then a full uniform frame of 0x10 → exactly 4 results, all 0, no stale outputs.
  - Separately, pixels presented in IDLE without `start_i` → no `valid_o`.
- **Reset mid-frame:** `rst_i` for one cycle after 11 pixels → the next cycle shows `valid_o` = `EdgeColor_o` = `done_o` = 0, and later pixels are ignored until `start_i`.
  - A subsequent ramp frame gives 120 ×4.
